// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined array multiplier and its product accumulator.
package mult_pkg;

    localparam int WIDTH = 8;

    typedef logic [2*WIDTH-1:0] prod_t;

    // A group of len products of width w each needs this many bits to avoid overflow.
    function automatic int acc_width(input int w, input int len);
        return 2 * w + $clog2(len);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Result stream leaving the product accumulator: valid/ready handshake plus status.
interface product_accumulator_if #(
    parameter int ACC_WIDTH = 18,
    parameter int LVL_W     = 3
) ();

    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 dropped;
    logic [LVL_W-1:0]     level;

    modport master (
        output out_valid,
        output out_sum,
        output dropped,
        output level,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_sum,
        input  dropped,
        input  level,
        output out_ready
    );

endinterface

// File: rtl/result_fifo.sv
// Circular-buffer result FIFO with a registered head; a push into a full FIFO
// is accepted when the head is popped in the same cycle.
module result_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4,
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_ready,
    output logic                  accept,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_next;
    logic [LVL_W-1:0]      level_next;
    logic [DATA_WIDTH-1:0] head_next;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop        = out_valid && pop_ready;
        accept     = push && ((level < LVL_W'(DEPTH)) || pop);
        rd_next    = pop ? ptr_inc(rd_ptr) : rd_ptr;
        level_next = level + LVL_W'(accept) - LVL_W'(pop);
        head_next  = out_data;
        // The new head may be the entry being written this very cycle.
        if (level_next != '0) begin
            if (accept && (wr_ptr == rd_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_next;
            level     <= level_next;
            out_valid <= (level_next != '0);
            out_data  <= head_next;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums each group of LEN multiplier products and queues the results; the
// multiplier cannot stall, so a result with no room is dropped and flagged.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH     = mult_pkg::WIDTH,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = acc_width(WIDTH, LEN),
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2*WIDTH-1:0]   P,
    input  logic                 done,
    input  logic                 clear,
    product_accumulator_if.master res
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]     count, eff_count;
    logic [ACC_WIDTH-1:0] acc, addend_base, sum;
    logic                 push, accept, drop, dropped_q;

    always_comb begin
        // A clear in the same cycle as done makes this product the first of a new group.
        eff_count   = clear ? '0 : count;
        addend_base = (eff_count == '0) ? '0 : acc;
        sum         = addend_base + ACC_WIDTH'(P);
        push        = done && (eff_count == CNT_W'(LEN - 1));
        drop        = push && !accept;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            acc       <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (done) begin
                if (push) begin
                    count <= '0;
                end else begin
                    count <= eff_count + 1'b1;
                    acc   <= sum;
                end
            end else if (clear) begin
                count <= '0;
            end
            if (drop) begin
                dropped_q <= 1'b1;
            end else if (clear) begin
                dropped_q <= 1'b0;
            end
        end
    end

    result_fifo #(
        .DATA_WIDTH (ACC_WIDTH),
        .DEPTH      (DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (sum),
        .pop_ready (res.out_ready),
        .accept    (accept),
        .out_valid (res.out_valid),
        .out_data  (res.out_sum),
        .level     (res.level)
    );

    assign res.dropped = dropped_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with WIDTH=8, LEN=4, DEPTH=4.
module tb_product_accumulator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] P = '0;
    logic        done = 1'b0;
    logic        clear = 1'b0;

    int errors = 0;
    int checks = 0;

    product_accumulator_if #(.ACC_WIDTH(18), .LVL_W(3)) bus ();

    product_accumulator #(
        .WIDTH (8),
        .LEN   (4),
        .DEPTH (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .P       (P),
        .done    (done),
        .clear   (clear),
        .res     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        done;
        logic [15:0] p;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic [17:0] es;
        logic        cs;
        logic [2:0]  el;
        logic        ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic d, input logic [15:0] p, input logic c, input logic r,
                       input logic ev, input logic [17:0] es, input logic cs,
                       input logic [2:0] el, input logic ed);
        vec_t v;
        v.done = d; v.p = p; v.clr = c; v.rdy = r;
        v.ev = ev; v.es = es; v.cs = cs; v.el = el; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic d, input logic [15:0] p, input logic c, input logic r);
        done = d; P = p; clear = c; bus.out_ready = r;
    endtask

    task automatic group(input logic [15:0] p, input logic r_last);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, p, 1'b0, (i == 3) ? r_last : 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.out_ready = 1'b0;

        // single group 3+5+7+11
        add(1, 3,  0, 1, 0, 0,  0, 0, 0);
        add(1, 5,  0, 1, 0, 0,  0, 0, 0);
        add(1, 7,  0, 1, 0, 0,  0, 0, 0);
        add(1, 11, 0, 1, 1, 26, 1, 1, 0);
        add(0, 0,  0, 1, 0, 0,  0, 0, 0);
        // four max products, held under backpressure
        add(1, 65025, 0, 0, 0, 0,      0, 0, 0);
        add(1, 65025, 0, 0, 0, 0,      0, 0, 0);
        add(1, 65025, 0, 0, 0, 0,      0, 0, 0);
        add(1, 65025, 0, 0, 1, 260100, 1, 1, 0);
        add(0, 0,     0, 0, 1, 260100, 1, 1, 0);
        add(0, 0,     0, 1, 0, 0,      0, 0, 0);
        // clear mid-group, with done in the clear cycle
        add(1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 5, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);

        #12;
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset out_sum",   32'(bus.out_sum),   0);
        check("reset level",     32'(bus.level),     0);
        check("reset dropped",   32'(bus.dropped),   0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].done, vecs[i].p, vecs[i].clr, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d level", i),     32'(bus.level),     32'(vecs[i].el));
            check($sformatf("vec%0d dropped", i),   32'(bus.dropped),   32'(vecs[i].ed));
            if (vecs[i].cs) begin
                check($sformatf("vec%0d out_sum", i), 32'(bus.out_sum), 32'(vecs[i].es));
            end
        end
        drive(0, 0, 0, 0);

        // backpressure: 20 products of 1 give five results of 4; the fifth is dropped
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        check("bp level",   32'(bus.level),   4);
        check("bp dropped", 32'(bus.dropped), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp pop%0d valid", i), 32'(bus.out_valid), 1);
            check($sformatf("bp pop%0d sum", i),   32'(bus.out_sum),   4);
            drive(0, 0, 0, 1);
            tick();
        end
        check("bp drained valid", 32'(bus.out_valid), 0);
        check("bp drained level", 32'(bus.level),     0);

        drive(0, 0, 1, 0);
        tick();
        check("clear dropped", 32'(bus.dropped), 0);

        // full FIFO with push and pop in the same cycle
        group(1, 0);
        group(2, 0);
        group(3, 0);
        group(4, 0);
        check("full level", 32'(bus.level), 4);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 0, 0);
            tick();
        end
        check("full head before pop", 32'(bus.out_sum), 4);
        drive(1, 5, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        check("pushpop level",   32'(bus.level),   4);
        check("pushpop dropped", 32'(bus.dropped), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("order%0d valid", i), 32'(bus.out_valid), 1);
            check($sformatf("order%0d sum", i),   32'(bus.out_sum),   32'(8 + 4 * i));
            drive(0, 0, 0, 1);
            tick();
        end
        check("order drained valid", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0);

        // async reset with results queued, dropped set, and a partial group
        for (int i = 0; i < 22; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        check("prereset level",   32'(bus.level),   4);
        check("prereset dropped", 32'(bus.dropped), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async out_valid", 32'(bus.out_valid), 0);
        check("async level",     32'(bus.level),     0);
        check("async dropped",   32'(bus.dropped),   0);
        #3;
        reset_n = 1'b1;
        tick();
        drive(1, 10, 0, 0); tick();
        drive(1, 20, 0, 0); tick();
        drive(1, 30, 0, 0); tick();
        drive(1, 40, 0, 0); tick();
        drive(0, 0, 0, 0);
        check("post reset valid", 32'(bus.out_valid), 1);
        check("post reset sum",   32'(bus.out_sum),   100);
        check("post reset level", 32'(bus.level),     1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the pipelined array multiplier. It takes the multiplier's product `P` and one-cycle `done` strobe, and sums every group of `LEN` consecutive products into one dot-product result. Completed results are buffered in a small FIFO and presented on a valid/ready output port. The multiplier cannot be stalled, so this block accepts every `done` pulse unconditionally and reports any result it has to drop.

## Interface
- `WIDTH`, default 8: multiplier operand width; products are `2*WIDTH` bits.
- `LEN`, default 4: number of products per result (≥1).
- `ACC_WIDTH`, default `2*WIDTH+$clog2(LEN)` (18): accumulator and result width.
- `DEPTH`, default 4: result FIFO entries (≥2).

Ports:
- `clock`, input, 1: the single clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `P`, input, `2*WIDTH`: product from the multiplier; sampled only when `done`=1.
- `done`, input, 1: product valid strobe; may be high every cycle.
- `clear`, input, 1: synchronous abort of the partial group; also clears `dropped`.
- `out_valid`, output, 1: FIFO head holds a result.
- `out_ready`, input, 1: consumer accepts the head this cycle.
- `out_sum`, output, `ACC_WIDTH`: FIFO head result.
- `dropped`, output, 1: sticky flag; set when a completed result was lost because the FIFO was full.
- `level`, output, `$clog2(DEPTH+1)`: FIFO occupancy.

## Operation
- Registers:
  - `count`, range 0..LEN-1, is the position in the current group.
  - `acc` holds the partial sum.
- On `done`:
  - If `count`==0, `addend_base`=0; otherwise `addend_base`=`acc`.
  - `sum = addend_base + zero_extend(P)`, computed modulo 2^ACC_WIDTH. Wrap-around is silent when `ACC_WIDTH` is undersized.
  - If `count`<LEN-1: `acc`<=`sum` and `count`<=`count`+1.
  - If `count`==LEN-1: push `sum` into the FIFO and set `count`<=0. `acc` is don't-care.
  - With LEN=1, every `done` pushes `zero_extend(P)`.
- `clear` resets `count` to 0 and discards the partial group. If `done` is high in the same cycle, that product starts the new group (`count`<=1, `acc`<=P). With LEN=1 it is pushed instead.
- FIFO push and pop:
  - A pop occurs when `out_valid`&&`out_ready`.
  - A push is accepted if `level`<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the result is discarded and `dropped`<=1.
- `dropped` update:
  - `clear` sets it to 0.
  - A drop in the same cycle as `clear` wins, so `dropped`=1.
- Results leave the FIFO in completion order. The FIFO is not flushed by `clear`.

## Timing
- Reset values: `out_valid`=0, `out_sum`=0, `dropped`=0, `level`=0, `count`=0, `acc`=0. Reset mid-group discards the group and all FIFO contents.
- Latency: `out_valid` rises on the cycle after the edge that samples the LEN-th `done`, provided the FIFO was empty.
- `out_sum` and `out_valid` are registered and stay stable while `out_valid`&&!`out_ready`.
- Full FIFO with a simultaneous push and pop: `level` is unchanged, and the new result becomes the tail.
- Empty FIFO with a simultaneous push: no pop is possible, since `out_valid`=0. No bypass; this gives the 1-cycle latency above.
- `out_ready` with `out_valid`=0 is ignored.
- Back-to-back `done` at full rate with `out_ready`=1 sustains one result every LEN cycles with no drops.

## Structure
- Shared package `mult_pkg`:
  - `WIDTH` default constant.
  - `prod_t` (`logic [2*WIDTH-1:0]`).
  - A function computing the default `ACC_WIDTH`.
  - The multiplier and this block both import it.
- Sub-module `result_fifo`:
  - Parameterised `DATA_WIDTH` and `DEPTH`.
  - Async active-low reset; pointer-based circular buffer with wrap-around.
  - Registered head, `level` output.
  - Push-when-full-with-pop rule implemented inside.
- Top level: group counter, accumulator, drop logic.

## Test plan
All scenarios use WIDTH=8, LEN=4, DEPTH=4.
- **Single group:** `done` with P=3,5,7,11 on consecutive cycles, `out_ready`=1 → one cycle after the 4th `done`: `out_valid`=1, `out_sum`=26, `level`=1.
- **Max values:** four `done` with P=65025 (255×255) → `out_sum`=260100, with no wrap in 18 bits.
- **Backpressure and drop:** `out_ready`=0, issue 20 `done` with P=1 → `level`=4, and each of the four queued `out_sum` values is 4. The 5th result is dropped and `dropped`=1. Then raise `out_ready` → four pops, after which `out_valid`=0.
- **Full FIFO, push and pop together:** fill the FIFO with results 4,8,12,16. Raise `out_ready` in the same cycle the 5th group completes (sum 20) → no drop, `level` stays 4, and the pop order is 4,8,12,16,20.
- **Clear mid-group:** P=9,9, then `clear` asserted with `done` P=2, then P=1,1,1 → result `out_sum`=5, and no result containing 9 is produced.
- **Async reset:** deassert `reset_n` mid-group and between clock edges with results queued → `out_valid`=0, `level`=0, `dropped`=0 immediately. After release, a fresh 4-product group yields the correct sum.
